ext_int_controller: RTL

- External interrupt controller between the KabIO peripherals and the Kabeta core interrupt interface (EIC_IntReq / EIC_IntId / EIC_IntAck).
- Collects per-device interrupt requests and applies per-source enable and edge/level mode.
- Arbitrates by fixed priority, presents one request with a stable ID to the core, and completes the request/acknowledge handshake.
- Configuration registers sit on the Sys_ I/O register bus.

---
 rtl/ext_int_controller.sv | 73 +++++++
 1 files changed

// File: rtl/ext_int_controller.sv
// ext_int_controller: external interrupt controller with per-source enable, edge/level mode,
// fixed lowest-index priority and a REQ/ACK/GAP handshake towards the core.
module ext_int_controller #(
   parameter int NUM_SRC  = 8,
   parameter int ID_WIDTH = 3
) (
   input  logic                Sys_Clock,
   input  logic                Sys_Reset,
   input  logic [NUM_SRC-1:0]  Src_IntReq,
   output logic [NUM_SRC-1:0]  Src_IntAck,
   input  logic                Sys_WrEn,
   input  logic                Sys_RdEn,
   input  logic [1:0]          Sys_Address,
   input  logic [31:0]         Sys_WrData,
   output logic [31:0]         Sys_RdData,
   output logic                EIC_IntReq,
   output logic [ID_WIDTH-1:0] EIC_IntId,
   input  logic                EIC_IntAck
);
   typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
   state_t state_q, state_d;
   logic [NUM_SRC-1:0]  enable_q, enable_d, mode_q, mode_d, pending_q, pending_d, prev_q;
   logic [NUM_SRC-1:0]  wr_mask, w1c, rise, eligible;
   logic [ID_WIDTH-1:0] id_q, id_d, winner;
   logic [31:0]         rd_data_q, rd_data_d, rd_sel, status;
   logic                unused_wr;
   assign unused_wr  = ^Sys_WrData;
   assign EIC_IntReq = (state_q == REQ);
   assign EIC_IntId  = id_q;
   assign Sys_RdData = rd_data_q;
   always_comb begin
      wr_mask  = Sys_WrData[NUM_SRC-1:0];
      eligible = pending_q & enable_q;
      winner   = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) if (eligible[i]) winner = ID_WIDTH'(i);
      // Ack is combinational so a level device sees it in time to drop during GAP
      Src_IntAck = (state_q == REQ && EIC_IntAck && !Sys_Reset) ? NUM_SRC'(1) << id_q : '0;
      rise       = Src_IntReq & ~prev_q;
      w1c        = (Sys_WrEn && Sys_Address == 2'd1) ? wr_mask : '0;
      pending_d  = (mode_q & (rise | (pending_q & ~(w1c | Src_IntAck)))) | (~mode_q & Src_IntReq);
      enable_d   = (Sys_WrEn && Sys_Address == 2'd0) ? wr_mask : enable_q;
      mode_d     = (Sys_WrEn && Sys_Address == 2'd2) ? wr_mask : mode_q;
      state_d    = state_q == IDLE ? (|eligible ? REQ : IDLE) :
                   state_q == REQ  ? (EIC_IntAck ? GAP : REQ) : IDLE;
      id_d       = (state_q == IDLE && |eligible) ? winner : id_q;
      rd_sel     = '0;
      rd_sel[NUM_SRC-1:0] = Sys_Address == 2'd0 ? enable_q :
                            Sys_Address == 2'd1 ? pending_q : mode_q;
      status     = '0;
      status[31] = EIC_IntReq;
      status[ID_WIDTH-1:0] = id_q;
      rd_data_d  = !Sys_RdEn ? rd_data_q : Sys_Address == 2'd3 ? status : rd_sel;
   end
   always_ff @(posedge Sys_Clock) begin
      if (Sys_Reset) begin
         state_q   <= IDLE;
         enable_q  <= '0;
         mode_q    <= '0;
         pending_q <= '0;
         prev_q    <= '0;
         id_q      <= '0;
         rd_data_q <= '0;
      end else begin
         state_q   <= state_d;
         enable_q  <= enable_d;
         mode_q    <= mode_d;
         pending_q <= pending_d;
         prev_q    <= Src_IntReq;
         id_q      <= id_d;
         rd_data_q <= rd_data_d;
      end
   end
endmodule
